local_pass_ctrl: RTL and testbench

LOCAL_PASS_CTRL -- requirements
Module: local_pass_ctrl

---
 rtl/local_pass_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_local_pass_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/local_pass_ctrl.sv
// Pass controller: loads weights and iacts from the GLB into PE clusters, starts compute,
// captures psums and drains them back, NUM_PASSES times. Define LOCAL_PASS_CTRL_TIMEOUT_EN for a compute watchdog.
module local_pass_ctrl #(
    parameter int unsigned DATA_BITWIDTH  = 16,
    parameter int unsigned ADDR_BITWIDTH  = 10,
    parameter int unsigned NUM_CLUSTERS   = 2,
    parameter int unsigned X_DIM          = 3,
    parameter int unsigned KERNEL_SIZE    = 3,
    parameter int unsigned ACT_SIZE       = 5,
    parameter int unsigned NUM_PASSES     = 2,
    parameter int unsigned W_BASE         = 0,
    parameter int unsigned A_BASE         = 100,
    parameter int unsigned PSUM_BASE      = 500,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          start,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          error,
    output logic [7:0]                                    pass_idx,
    output logic                                          glb_req_wght,
    output logic [ADDR_BITWIDTH-1:0]                      glb_addr_wght,
    input  logic [DATA_BITWIDTH-1:0]                      glb_data_wght,
    output logic                                          glb_req_iact,
    output logic [ADDR_BITWIDTH-1:0]                      glb_addr_iact,
    input  logic [DATA_BITWIDTH-1:0]                      glb_data_iact,
    output logic [NUM_CLUSTERS-1:0]                       pe_load_en_wght,
    output logic [DATA_BITWIDTH-1:0]                      pe_data_wght,
    output logic [NUM_CLUSTERS-1:0]                       pe_load_en_iact,
    output logic [DATA_BITWIDTH-1:0]                      pe_data_iact,
    output logic [NUM_CLUSTERS-1:0]                       pe_start,
    input  logic [NUM_CLUSTERS-1:0]                       pe_compute_done,
    input  logic [DATA_BITWIDTH*X_DIM*NUM_CLUSTERS-1:0]   pe_psum,
    output logic                                          psum_we,
    output logic [ADDR_BITWIDTH-1:0]                      psum_addr,
    output logic [DATA_BITWIDTH-1:0]                      psum_data
);

    localparam int unsigned K2        = KERNEL_SIZE * KERNEL_SIZE;
    localparam int unsigned A2        = ACT_SIZE * ACT_SIZE;
    localparam int unsigned NPSUM     = X_DIM * NUM_CLUSTERS;
    localparam int unsigned MAX_BEATS = (K2 > A2) ? ((K2 > NPSUM) ? K2 : NPSUM)
                                                  : ((A2 > NPSUM) ? A2 : NPSUM);
    localparam int unsigned CNT_W     = $clog2(MAX_BEATS + 1);
    localparam int unsigned CL_W      = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1;

    typedef enum logic [2:0] {
        StIdle, StLoadW, StLoadA, StSync, StCompute, StDrain, StDone
    } state_e;

    state_e                                  state_q, state_d;
    logic [CNT_W-1:0]                        cnt_q, cnt_d;
    logic [CL_W-1:0]                         wc_q, wc_d;
    logic [7:0]                              pass_q, pass_d;
    logic [NUM_CLUSTERS-1:0]                 done_bits_q, done_bits_d;
    logic [NPSUM-1:0][DATA_BITWIDTH-1:0]     psum_q, psum_d;
    logic [NUM_CLUSTERS-1:0]                 wght_en_q, wght_en_d;
    logic                                    iact_en_q, iact_en_d;
    logic                                    start_pulse_q, start_pulse_d;
    logic [DATA_BITWIDTH-1:0]                psum_sel;

`ifdef LOCAL_PASS_CTRL_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            error_q, error_d;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wc_d          = wc_q;
        pass_d        = pass_q;
        done_bits_d   = done_bits_q;
        psum_d        = psum_q;
        wght_en_d     = '0;
        iact_en_d     = 1'b0;
        start_pulse_d = 1'b0;
`ifdef LOCAL_PASS_CTRL_TIMEOUT_EN
        wd_d          = wd_q;
        error_d       = error_q;
`endif
        glb_req_wght  = 1'b0;
        glb_req_iact  = 1'b0;
        psum_we       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StLoadW;
                    cnt_d       = '0;
                    wc_d        = '0;
                    pass_d      = '0;
                    done_bits_d = '0;
`ifdef LOCAL_PASS_CTRL_TIMEOUT_EN
                    error_d     = 1'b0;
`endif
                end
            end
            StLoadW: begin
                glb_req_wght = 1'b1;
                for (int c = 0; c < NUM_CLUSTERS; c++) begin
                    if (wc_q == CL_W'(c)) wght_en_d[c] = 1'b1;
                end
                if (cnt_q == CNT_W'(K2 - 1)) begin
                    cnt_d = '0;
                    if (wc_q == CL_W'(NUM_CLUSTERS - 1)) begin
                        wc_d    = '0;
                        state_d = StLoadA;
                    end else begin
                        wc_d = wc_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StLoadA: begin
                glb_req_iact = 1'b1;
                iact_en_d    = 1'b1;
                if (cnt_q == CNT_W'(A2 - 1)) begin
                    cnt_d   = '0;
                    state_d = StSync;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StSync: begin
                // The last iact beat lands here; pe_start follows in the first COMPUTE cycle.
                state_d       = StCompute;
                start_pulse_d = 1'b1;
`ifdef LOCAL_PASS_CTRL_TIMEOUT_EN
                wd_d          = '0;
`endif
            end
            StCompute: begin
                for (int c = 0; c < NUM_CLUSTERS; c++) begin
                    if (pe_compute_done[c] && !done_bits_q[c]) begin
                        done_bits_d[c] = 1'b1;
                        for (int j = 0; j < X_DIM; j++) begin
                            psum_d[c*X_DIM + j] =
                                pe_psum[(c*X_DIM + j)*DATA_BITWIDTH +: DATA_BITWIDTH];
                        end
                    end
                end
                if (&done_bits_d) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end
`ifdef LOCAL_PASS_CTRL_TIMEOUT_EN
                else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = StDone;
                    error_d = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            StDrain: begin
                psum_we = 1'b1;
                if (cnt_q == CNT_W'(NPSUM - 1)) begin
                    cnt_d       = '0;
                    done_bits_d = '0;
                    pass_d      = pass_q + 1'b1;
                    state_d     = (pass_q == 8'(NUM_PASSES - 1)) ? StDone : StLoadW;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                pass_d  = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        psum_sel = '0;
        for (int k = 0; k < NPSUM; k++) begin
            if (cnt_q == CNT_W'(k)) psum_sel = psum_q[k];
        end
    end

    // Every output is gated so reset drives all of them to zero on the following cycle.
    assign busy            = (state_q != StIdle);
    assign done            = (state_q == StDone);
    assign pass_idx        = pass_q;
    assign glb_addr_wght   = glb_req_wght ?
        ADDR_BITWIDTH'(W_BASE + 32'(pass_q) * (NUM_CLUSTERS * K2) + 32'(wc_q) * K2
                       + 32'(cnt_q)) : '0;
    assign glb_addr_iact   = glb_req_iact ?
        ADDR_BITWIDTH'(A_BASE + 32'(pass_q) * A2 + 32'(cnt_q)) : '0;
    assign pe_load_en_wght = wght_en_q;
    assign pe_data_wght    = (|wght_en_q) ? glb_data_wght : '0;
    assign pe_load_en_iact = {NUM_CLUSTERS{iact_en_q}};
    assign pe_data_iact    = iact_en_q ? glb_data_iact : '0;
    assign pe_start        = {NUM_CLUSTERS{start_pulse_q}};
    assign psum_addr       = psum_we ?
        ADDR_BITWIDTH'(PSUM_BASE + 32'(pass_q) * NPSUM + 32'(cnt_q)) : '0;
    assign psum_data       = psum_we ? psum_sel : '0;

`ifdef LOCAL_PASS_CTRL_TIMEOUT_EN
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            wc_q          <= '0;
            pass_q        <= '0;
            done_bits_q   <= '0;
            psum_q        <= '0;
            wght_en_q     <= '0;
            iact_en_q     <= 1'b0;
            start_pulse_q <= 1'b0;
`ifdef LOCAL_PASS_CTRL_TIMEOUT_EN
            wd_q          <= '0;
            error_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wc_q          <= wc_d;
            pass_q        <= pass_d;
            done_bits_q   <= done_bits_d;
            psum_q        <= psum_d;
            wght_en_q     <= wght_en_d;
            iact_en_q     <= iact_en_d;
            start_pulse_q <= start_pulse_d;
`ifdef LOCAL_PASS_CTRL_TIMEOUT_EN
            wd_q          <= wd_d;
            error_q       <= error_d;
`endif
        end
    end

endmodule

// File: tb/tb_local_pass_ctrl.sv
// Scoreboard bench for local_pass_ctrl: stimulus and a PE model push expectations,
// a negedge monitor pops and compares them.
module tb_local_pass_ctrl;

    localparam int DW = 16, AW = 10, NC = 2, XD = 3, KS = 3, AS = 5, NP = 2;
    localparam int K2 = KS * KS, A2 = AS * AS, NPS = XD * NC;
`ifdef LOCAL_PASS_CTRL_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic                 clk = 1'b0;
    logic                 reset, start;
    logic                 busy, done, error;
    logic [7:0]           pass_idx;
    logic                 glb_req_wght, glb_req_iact;
    logic [AW-1:0]        glb_addr_wght, glb_addr_iact;
    logic [DW-1:0]        glb_data_wght, glb_data_iact;
    logic [NC-1:0]        pe_load_en_wght, pe_load_en_iact, pe_start, pe_compute_done;
    logic [DW-1:0]        pe_data_wght, pe_data_iact;
    logic [DW*XD*NC-1:0]  pe_psum;
    logic                 psum_we;
    logic [AW-1:0]        psum_addr;
    logic [DW-1:0]        psum_data;

    local_pass_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .error(error),
        .pass_idx(pass_idx),
        .glb_req_wght(glb_req_wght), .glb_addr_wght(glb_addr_wght),
        .glb_data_wght(glb_data_wght),
        .glb_req_iact(glb_req_iact), .glb_addr_iact(glb_addr_iact),
        .glb_data_iact(glb_data_iact),
        .pe_load_en_wght(pe_load_en_wght), .pe_data_wght(pe_data_wght),
        .pe_load_en_iact(pe_load_en_iact), .pe_data_iact(pe_data_iact),
        .pe_start(pe_start), .pe_compute_done(pe_compute_done), .pe_psum(pe_psum),
        .psum_we(psum_we), .psum_addr(psum_addr), .psum_data(psum_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int addr; int data; } exp_t;
    exp_t wq[$], iq[$], sq[$], pq[$], dq[$];

    int checks = 0, passes = 0;
    int d0, d1, pe_pass, run_id, exp_done_cyc, t0;
    bit pe_mode;
    int pend_w_en;
    logic [DW-1:0] pend_w_data, pend_i_data;
    bit pend_i, after_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    endtask

    function automatic logic [DW-1:0] wmem(input int a);
        return {6'h2A, 10'(a)};
    endfunction
    function automatic logic [DW-1:0] imem(input int a);
        return {6'h15, 10'(a)};
    endfunction
    function automatic logic [DW-1:0] pval(input int r, input int p, input int c, input int j);
        return 16'(r * 4096 + p * 256 + c * 16 + j + 1);
    endfunction

    // Expected request/start timeline of one pass whose LOAD_W begins at cycle l.
    task automatic push_pass(input int p, input int l);
        for (int c = 0; c < NC; c++)
            for (int i = 0; i < K2; i++)
                wq.push_back('{l + c*K2 + i, (p*NC*K2 + c*K2 + i) % 1024, 1 << c});
        for (int i = 0; i < A2; i++)
            iq.push_back('{l + NC*K2 + i, (100 + p*A2 + i) % 1024, 0});
        sq.push_back('{l + NC*K2 + A2 + 1, 0, 3});
    endtask

    task automatic flush();
        wq.delete(); iq.delete(); sq.delete(); pq.delete(); dq.delete();
        pend_w_en = 0; pend_i = 0; pe_pass = 0; after_done = 0;
    endtask

    // GLB: data valid the cycle after a request.
    always @(posedge clk) begin
        glb_data_wght <= glb_req_wght ? wmem(int'(glb_addr_wght)) : 16'h0;
        glb_data_iact <= glb_req_iact ? imem(int'(glb_addr_iact)) : 16'h0;
    end

    // PE model: answers pe_start after per-cluster delays and predicts the drain.
    initial begin
        int s, dmax, dstart;
        int dly[NC];
        logic [DW-1:0] cap[NPS];
        logic [NC-1:0] dv;
        logic [DW*XD*NC-1:0] pv;
        pe_compute_done = '0;
        pe_psum = '0;
        forever begin
            @(negedge clk);
            if (pe_start != '0 && !pe_mode) begin
                s = cyc;
                dly[0] = d0;
                dly[1] = d1;
                dmax = (d0 > d1) ? d0 : d1;
                for (int k = 0; k <= dmax; k++) begin
                    if (k > 0) @(negedge clk);
                    dv = '0;
                    pv = {(XD*NC){16'hDEAD}};
                    for (int c = 0; c < NC; c++) begin
                        if (k == dly[c]) begin
                            dv[c] = 1'b1;
                            for (int j = 0; j < XD; j++) begin
                                cap[c*XD + j] = pval(run_id, pe_pass, c, j);
                                pv[(c*XD + j)*DW +: DW] = cap[c*XD + j];
                            end
                        end
                    end
                    pe_compute_done = dv;
                    pe_psum = pv;
                end
                dstart = s + dmax + 1;
                for (int k = 0; k < NPS; k++)
                    pq.push_back('{dstart + k, (500 + pe_pass*NPS + k) % 1024, int'(cap[k])});
                if (pe_pass == NP - 1) begin
                    exp_done_cyc = dstart + NPS;
                    dq.push_back('{exp_done_cyc, 0, 0});
                    pe_pass = 0;
                end else begin
                    push_pass(pe_pass + 1, dstart + NPS);
                    pe_pass++;
                end
                @(negedge clk);
                pe_compute_done = '0;
                pe_psum = {(XD*NC){16'hBEEF}};
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an output.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (pend_w_en != 0 || pe_load_en_wght != '0) begin
                check("wght_beat_en", 32'(pe_load_en_wght), 32'(pend_w_en));
                if (pend_w_en != 0) check("wght_beat_data", 32'(pe_data_wght), 32'(pend_w_data));
            end
            pend_w_en = 0;
            if (glb_req_wght) begin
                if (wq.size() == 0) check("wght_req_unexpected", 32'(glb_req_wght), 0);
                else begin
                    e = wq.pop_front();
                    check("wght_req_cyc", cyc, e.cyc);
                    check("wght_req_addr", 32'(glb_addr_wght), e.addr);
                    pend_w_en = e.data;
                    pend_w_data = wmem(e.addr);
                end
            end
            if (pend_i || pe_load_en_iact != '0) begin
                check("iact_beat_en", 32'(pe_load_en_iact), pend_i ? 32'h3 : 32'h0);
                if (pend_i) check("iact_beat_data", 32'(pe_data_iact), 32'(pend_i_data));
            end
            pend_i = 0;
            if (glb_req_iact) begin
                if (iq.size() == 0) check("iact_req_unexpected", 32'(glb_req_iact), 0);
                else begin
                    e = iq.pop_front();
                    check("iact_req_cyc", cyc, e.cyc);
                    check("iact_req_addr", 32'(glb_addr_iact), e.addr);
                    pend_i = 1;
                    pend_i_data = imem(e.addr);
                end
            end
            if (pe_start != '0) begin
                if (sq.size() == 0) check("pe_start_unexpected", 32'(pe_start), 0);
                else begin
                    e = sq.pop_front();
                    check("pe_start_cyc", cyc, e.cyc);
                    check("pe_start_val", 32'(pe_start), e.data);
                end
            end
            if (psum_we) begin
                if (pq.size() == 0) check("psum_we_unexpected", 32'(psum_we), 0);
                else begin
                    e = pq.pop_front();
                    check("psum_cyc", cyc, e.cyc);
                    check("psum_addr", 32'(psum_addr), e.addr);
                    check("psum_data", 32'(psum_data), e.data);
                end
            end
            if (after_done) begin
                check("post_done_busy", 32'(busy), 0);
                check("post_done_done", 32'(done), 0);
                check("post_done_pass_idx", 32'(pass_idx), 0);
                after_done = 0;
            end
            if (done) begin
                if (dq.size() == 0) check("done_unexpected", 32'(done), 0);
                else begin
                    e = dq.pop_front();
                    check("done_cyc", cyc, e.cyc);
                    check("done_busy", 32'(busy), 1);
                    after_done = 1;
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_error"}, 32'(error), 0);
        check({tag, "_pass_idx"}, 32'(pass_idx), 0);
        check({tag, "_req"}, {30'd0, glb_req_wght, glb_req_iact}, 0);
        check({tag, "_glb_addr"}, {12'd0, glb_addr_wght, glb_addr_iact}, 0);
        check({tag, "_load_en"}, {28'd0, pe_load_en_wght, pe_load_en_iact}, 0);
        check({tag, "_pe_data"}, {pe_data_wght, pe_data_iact}, 0);
        check({tag, "_pe_start"}, 32'(pe_start), 0);
        check({tag, "_psum"}, {5'd0, psum_we, psum_addr, psum_data}, 0);
    endtask

    task automatic start_run();
        @(posedge clk); #1;
        start = 1'b1;
        t0 = cyc;
        run_id++;
        push_pass(0, t0 + 1);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) check("done_wait_expired", 32'(done), 1);
    endtask

    task automatic end_run(input string tag);
        @(negedge clk);
        check({tag, "_wq_left"}, wq.size(), 0);
        check({tag, "_iq_left"}, iq.size(), 0);
        check({tag, "_sq_left"}, sq.size(), 0);
        check({tag, "_pq_left"}, pq.size(), 0);
        check({tag, "_dq_left"}, dq.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d, want completion", cyc);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; pe_mode = 0; d0 = 1; d1 = 4; run_id = 0;
        exp_done_cyc = 0;
        flush();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // Cluster 0 done three cycles before cluster 1.
        start_run();
        wait_done(2000);
        end_run("run_a");

        // Start held high; both clusters done in the pe_start cycle, then cluster 1 first.
        d0 = 0; d1 = 0;
        @(posedge clk); #1;
        start = 1'b1;
        t0 = cyc;
        run_id++;
        push_pass(0, t0 + 1);
        wait_done(2000);
        run_id++;
        d0 = 3; d1 = 0;
        push_pass(0, exp_done_cyc + 2);
        wait_done(2000);
        start = 1'b0;
        end_run("run_held");
        repeat (3) @(negedge clk);
        check("no_restart_busy", 32'(busy), 0);

        // Reset in the middle of LOAD_A, then a clean rerun.
        d0 = 1; d1 = 2;
        start_run();
        while (cyc < t0 + 25) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        flush();
        @(negedge clk);
        check_all_zero("mid_reset");
        start_run();
        wait_done(2000);
        end_run("rerun");

        // PE never reports done.
        pe_mode = 1;
        start_run();
`ifdef LOCAL_PASS_CTRL_TIMEOUT_EN
        dq.push_back('{t0 + 45 + TO, 0, 0});
        wait_done(2000);
        check("timeout_error", 32'(error), 1);
        @(negedge clk);
        check("timeout_error_sticky", 32'(error), 1);
        end_run("timeout");
        pe_mode = 0;
        start_run();
        @(negedge clk);
        check("error_cleared_by_start", 32'(error), 0);
        wait_done(2000);
        end_run("after_timeout");
`else
        while (cyc < t0 + 45 + 60) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("hang_busy", 32'(busy), 1);
        check("hang_error", 32'(error), 0);
        check("hang_psum_we", 32'(psum_we), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        flush();
        pe_mode = 0;
        @(negedge clk);
        check_all_zero("hang_reset");
`endif
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
